// File: rtl/kmeans_load_sequencer.sv
// kmeans_load_sequencer: APB master that streams sample words into the k-means
// register file RAM window, programs the address range, launches the core,
// waits for its interrupt and reads back internal_status.
module kmeans_load_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 91,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int PREADY_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH-1:0] first_addr,
  input  logic [RAM_ADDR_WIDTH:0]   word_count,
  input  logic                      s_valid,
  input  logic [DATA_WIDTH-1:0]     s_data,
  output logic                      s_ready,
  input  logic                      interupt,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pready,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [DATA_WIDTH-1:0]     status
);
  localparam int CW = (PREADY_TIMEOUT < 2) ? 1 : $clog2(PREADY_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(PREADY_TIMEOUT - 1);
  localparam logic [RAM_ADDR_WIDTH+1:0] RAM_SIZE = (RAM_ADDR_WIDTH+2)'(1) << RAM_ADDR_WIDTH;
  localparam logic [RAM_ADDR_WIDTH:0]   ONE_C = (RAM_ADDR_WIDTH+1)'(1);
  localparam logic [RAM_ADDR_WIDTH-1:0] ONE_A = RAM_ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, SETUP, ACCESS, NEXT, WAIT_IRQ, FINISH} state_t;
  typedef enum logic [2:0] {OP_RADDR, OP_RDATA, OP_FIRST, OP_LAST, OP_GO, OP_STAT} op_t;

  state_t state, state_nxt;
  op_t    op, op_nxt;

  logic [RAM_ADDR_WIDTH-1:0] first_r;
  logic [RAM_ADDR_WIDTH:0]   count_r, idx;
  logic [DATA_WIDTH-1:0]     word_r, status_r;
  logic [CW-1:0]             tmo_cnt;
  logic                      error_r;

  logic [RAM_ADDR_WIDTH+1:0] range_end;
  logic                      args_bad, last_word;
  logic [RAM_ADDR_WIDTH-1:0] cur_addr, last_addr;

  // range_end is one past the last address; anything beyond the RAM is rejected
  assign range_end = {2'b00, first_r} + {1'b0, count_r};
  assign args_bad  = (count_r == '0) || (range_end > RAM_SIZE);
  assign last_word = (idx == count_r - ONE_C);
  assign cur_addr  = first_r + idx[RAM_ADDR_WIDTH-1:0];
  assign last_addr = first_r + count_r[RAM_ADDR_WIDTH-1:0] - ONE_A;

  assign s_ready = (state == FETCH);
  assign busy    = (state != IDLE);
  assign done    = (state == FINISH);
  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = (state == ACCESS);
  assign error   = error_r;
  assign status  = status_r;

  // APB address/data decode from the current op; forced to zero when the bus is idle
  always_comb begin
    paddr  = '0;
    pwrite = 1'b0;
    pwdata = '0;
    if (psel) begin
      case (op)
        OP_RADDR: begin paddr = ADDR_WIDTH'(10); pwrite = 1'b1; pwdata = DATA_WIDTH'(cur_addr); end
        OP_RDATA: begin paddr = ADDR_WIDTH'(11); pwrite = 1'b1; pwdata = word_r; end
        OP_FIRST: begin paddr = ADDR_WIDTH'(12); pwrite = 1'b1; pwdata = DATA_WIDTH'(first_r); end
        OP_LAST:  begin paddr = ADDR_WIDTH'(13); pwrite = 1'b1; pwdata = DATA_WIDTH'(last_addr); end
        OP_GO:    begin paddr = ADDR_WIDTH'(1);  pwrite = 1'b1; pwdata = DATA_WIDTH'(1); end
        default:  begin paddr = ADDR_WIDTH'(0);  pwrite = 1'b0; end
      endcase
    end
  end

  // state and op registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= OP_RADDR;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
    end
  end

  // next-state and op sequencing
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    case (state)
      IDLE:     if (start) state_nxt = CHECK;
      CHECK:    state_nxt = args_bad ? FINISH : FETCH;
      FETCH:    if (s_valid) begin state_nxt = SETUP; op_nxt = OP_RADDR; end
      SETUP:    state_nxt = ACCESS;
      ACCESS:   if (pready) state_nxt = NEXT;
                else if (tmo_cnt == TMO_LAST) state_nxt = FINISH;
      NEXT: begin
        case (op)
          OP_RADDR: begin op_nxt = OP_RDATA; state_nxt = SETUP; end
          OP_RDATA: if (last_word) begin op_nxt = OP_FIRST; state_nxt = SETUP; end
                    else state_nxt = FETCH;
          OP_FIRST: begin op_nxt = OP_LAST; state_nxt = SETUP; end
          OP_LAST:  begin op_nxt = OP_GO; state_nxt = SETUP; end
          OP_GO:    state_nxt = WAIT_IRQ;
          default:  state_nxt = FINISH;
        endcase
      end
      WAIT_IRQ: if (interupt) begin op_nxt = OP_STAT; state_nxt = SETUP; end
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // datapath: argument latch, word capture, word index, pready timeout, result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_r  <= '0;
      count_r  <= '0;
      idx      <= '0;
      word_r   <= '0;
      status_r <= '0;
      tmo_cnt  <= '0;
      error_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          first_r  <= first_addr;
          count_r  <= word_count;
          idx      <= '0;
          error_r  <= 1'b0;
          status_r <= '0;
        end
        CHECK:  if (args_bad) error_r <= 1'b1;
        FETCH:  if (s_valid) word_r <= s_data;
        SETUP:  tmo_cnt <= '0;
        ACCESS: begin
          if (pready) begin
            if (op == OP_STAT) status_r <= prdata;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
            if (tmo_cnt == TMO_LAST) error_r <= 1'b1;
          end
        end
        NEXT:   if (op == OP_RDATA && !last_word) idx <= idx + ONE_C;
        default: ;
      endcase
    end
  end
endmodule
